// File: rtl/neu_par.sv
// Grid-node relaxation unit: keeps one node's weight, best path cost and back-pointer,
// relaxing LANES of its 8 neighbours per active cycle. Optional upd_cnt via NEU_PAR_TRACE_EN.
module neu_par #(
  parameter int unsigned COST_W   = 12,
  parameter int unsigned WEIGHT_W = 4,
  parameter int unsigned LANES    = 2,
  parameter int unsigned PERP     = 2,
  parameter int unsigned DIAG     = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  ld,
  input  logic [WEIGHT_W-1:0]   ld_weight,
  input  logic                  en,
  input  logic [8*COST_W-1:0]   nbr_cost,
  output logic [COST_W-1:0]     path_cost,
  output logic [2:0]            path_dir,
  output logic                  path_mod,
  output logic                  path_stable
`ifdef NEU_PAR_TRACE_EN
  ,
  output logic [15:0]           upd_cnt
`endif
);

  localparam int unsigned TW = COST_W + 1;
  localparam int unsigned SweepLen = 8 / LANES;
  localparam logic [COST_W-1:0]   CostInf   = '1;
  localparam logic [WEIGHT_W-1:0] WeightInf = '1;
  localparam logic [2:0]          PtrStep   = 3'(LANES % 8);
  localparam logic [3:0]          StableMax = 4'hF;
  localparam logic [3:0]          StableThr = 4'(SweepLen);

  logic [WEIGHT_W-1:0] weight_q;
  logic [COST_W-1:0]   cost_q;
  logic [2:0]          dir_q;
  logic [2:0]          ptr_q;
  logic                mod_q;
  logic [3:0]          stable_q;

  logic accessible;
  logic active;
  logic update;

  assign accessible = (weight_q != WeightInf);
  assign active     = !clr && !ld && en && accessible;

  // Per-lane candidate evaluation; travel carries one extra bit to catch overflow.
  logic [TW-1:0] wt_term;
  logic [2:0]    lane_dir    [LANES];
  logic [TW-1:0] lane_travel [LANES];
  logic          lane_ok     [LANES];

  assign wt_term = TW'({weight_q, 1'b0});

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    logic [COST_W-1:0] nbr;
    assign lane_dir[g]    = ptr_q + 3'(g);
    assign nbr            = nbr_cost[lane_dir[g]*COST_W +: COST_W];
    assign lane_travel[g] = TW'(nbr) + wt_term + (lane_dir[g][0] ? TW'(DIAG) : TW'(PERP));
    assign lane_ok[g]     = (nbr != CostInf) && !lane_travel[g][COST_W];
  end

  logic          best_valid;
  logic [TW-1:0] best_cost;
  logic [2:0]    best_dir;

  // Lanes cover ascending directions (ptr is a multiple of LANES), so a strict
  // compare in lane order resolves ties to the lowest direction.
  always_comb begin
    best_valid = 1'b0;
    best_cost  = '1;
    best_dir   = '0;
    for (int i = 0; i < LANES; i++) begin
      if (lane_ok[i] && (!best_valid || lane_travel[i] < best_cost)) begin
        best_valid = 1'b1;
        best_cost  = lane_travel[i];
        best_dir   = lane_dir[i];
      end
    end
  end

  assign update = active && best_valid && (best_cost < {1'b0, cost_q});

  always_ff @(posedge clk) begin
    if (rst) begin
      weight_q <= WeightInf;
      cost_q   <= CostInf;
      dir_q    <= '0;
      ptr_q    <= '0;
      mod_q    <= 1'b0;
      stable_q <= '0;
    end else if (clr || ld) begin
      if (clr) begin
        cost_q <= '0;
        dir_q  <= '0;
      end
      if (ld) begin
        weight_q <= ld_weight;
      end
      mod_q    <= 1'b0;
      stable_q <= '0;
      ptr_q    <= '0;
    end else if (active) begin
      ptr_q <= ptr_q + PtrStep;
      if (update) begin
        cost_q   <= best_cost[COST_W-1:0];
        dir_q    <= best_dir;
        mod_q    <= 1'b1;
        stable_q <= '0;
      end else begin
        mod_q <= 1'b0;
        if (stable_q != StableMax) begin
          stable_q <= stable_q + 4'd1;
        end
      end
    end else begin
      mod_q <= 1'b0;
    end
  end

`ifdef NEU_PAR_TRACE_EN
  logic [15:0] upd_q;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      upd_q <= '0;
    end else if (update && upd_q != 16'hFFFF) begin
      upd_q <= upd_q + 16'd1;
    end
  end

  assign upd_cnt = upd_q;
`endif

  assign path_cost   = cost_q;
  assign path_dir    = dir_q;
  assign path_mod    = mod_q;
  assign path_stable = (stable_q >= StableThr) || !accessible;

endmodule

// File: tb/tb_neu_par.sv
// Directed bench for neu_par: per-cycle comparison against an arithmetic model of the
// relaxation rules, plus literal expectations at key points of each scenario.
module tb_neu_par;

  localparam int L = 2;
  localparam int INF = 4095;

  logic        clk = 1'b0;
  logic        rst, clr, ld, en;
  logic [3:0]  ld_weight;
  logic [95:0] nbr_cost;
  logic [11:0] path_cost;
  logic [2:0]  path_dir;
  logic        path_mod, path_stable;
`ifdef NEU_PAR_TRACE_EN
  logic [15:0] upd_cnt;
`endif

  int nb[8];
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  always_comb begin
    nbr_cost = '0;
    for (int k = 0; k < 8; k++) nbr_cost[k*12 +: 12] = 12'(nb[k]);
  end

  neu_par #(.COST_W(12), .WEIGHT_W(4), .LANES(L), .PERP(2), .DIAG(3)) dut (
    .clk(clk), .rst(rst), .clr(clr), .ld(ld), .ld_weight(ld_weight), .en(en),
    .nbr_cost(nbr_cost), .path_cost(path_cost), .path_dir(path_dir),
    .path_mod(path_mod), .path_stable(path_stable)
`ifdef NEU_PAR_TRACE_EN
    , .upd_cnt(upd_cnt)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Model state: what the node must hold after each clock edge.
  int m_w, m_cost, m_dir, m_ptr, m_mod, m_stab, m_upd;
  bit chk_on = 0;

  task automatic model_advance();
    int best, bd, d, t;
    if (rst) begin
      m_w = 15; m_cost = INF; m_dir = 0; m_ptr = 0; m_mod = 0; m_stab = 0; m_upd = 0;
    end else if (clr || ld) begin
      if (clr) begin m_cost = 0; m_dir = 0; m_upd = 0; end
      if (ld) m_w = int'(ld_weight);
      m_mod = 0; m_stab = 0; m_ptr = 0;
    end else if (en && m_w != 15) begin
      best = -1; bd = 0;
      for (int k = 0; k < L; k++) begin
        d = (m_ptr + k) % 8;
        if (nb[d] != INF) begin
          t = nb[d] + 2 * m_w + ((d % 2 == 1) ? 3 : 2);
          if (t < 4096 && (best < 0 || t < best || (t == best && d < bd))) begin
            best = t; bd = d;
          end
        end
      end
      m_ptr = (m_ptr + L) % 8;
      if (best >= 0 && best < m_cost) begin
        m_cost = best; m_dir = bd; m_mod = 1; m_stab = 0;
        if (m_upd < 65535) m_upd++;
      end else begin
        m_mod = 0; m_stab++;
      end
    end else begin
      m_mod = 0;
    end
  endtask

  // Inputs only change 2 time units after a rising edge, so at the falling edge
  // they are exactly what the next rising edge will sample.
  initial begin
    forever begin
      @(negedge clk);
      if (chk_on) begin
        check("cost", 32'(path_cost), 32'(m_cost));
        check("dir", 32'(path_dir), 32'(m_dir));
        check("mod", 32'(path_mod), 32'(m_mod));
        check("stable", 32'(path_stable), 32'((m_stab >= 8 / L) || (m_w == 15)));
`ifdef NEU_PAR_TRACE_EN
        check("upd_cnt", 32'(upd_cnt), 32'(m_upd));
`endif
      end
      model_advance();
      if (rst) chk_on = 1;
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic set_all(input int v);
    for (int k = 0; k < 8; k++) nb[k] = v;
  endtask

  initial begin
    rst = 1; clr = 0; ld = 0; en = 0; ld_weight = 0; set_all(INF);
    step(2);
    check("rst_cost", 32'(path_cost), 32'hFFF);
    check("rst_stable", 32'(path_stable), 1);
    check("rst_mod", 32'(path_mod), 0);

    // Converge on INF
    rst = 0; ld = 1; ld_weight = 1;
    step(1);
    ld = 0; en = 1;
    check("inf_notstable", 32'(path_stable), 0);
    step(4);
    check("inf_cost", 32'(path_cost), 32'hFFF);
    check("inf_stable", 32'(path_stable), 1);

    // Perpendicular relax: 10 + 2 + 2
    nb[0] = 10;
    step(1);
    check("perp_cost", 32'(path_cost), 14);
    check("perp_dir", 32'(path_dir), 0);
    check("perp_mod", 32'(path_mod), 1);
    step(1);
    check("perp_mod_low", 32'(path_mod), 0);
    step(3);
    check("perp_stable", 32'(path_stable), 1);

    // Tie across cycles: NE wins first, E=10 equal so ignored, then E=9 improves
    rst = 1; en = 0; set_all(INF);
    step(1);
    rst = 0; ld = 1; ld_weight = 1;
    step(1);
    ld = 0; en = 1; nb[1] = 9; nb[2] = 10;
    step(1);
    check("tie_cost", 32'(path_cost), 14);
    check("tie_dir", 32'(path_dir), 1);
    step(1);
    check("tie_hold_dir", 32'(path_dir), 1);
    nb[2] = 9;
    step(4);
    check("tie2_cost", 32'(path_cost), 13);
    check("tie2_dir", 32'(path_dir), 2);

    // Same-cycle tie N vs NE -> lower direction
    rst = 1; en = 0; set_all(INF);
    step(1);
    rst = 0; ld = 1; ld_weight = 1;
    step(1);
    ld = 0; en = 1; nb[0] = 10; nb[1] = 9;
    step(1);
    check("tie_same_dir", 32'(path_dir), 0);
    check("tie_same_cost", 32'(path_cost), 14);

    // Source with simultaneous ld
    rst = 1; en = 0; set_all(INF);
    step(1);
    rst = 0; clr = 1; ld = 1; ld_weight = 2; set_all(0); en = 1;
    step(1);
    clr = 0; ld = 0;
    check("src_cost", 32'(path_cost), 0);
    check("src_stable0", 32'(path_stable), 0);
    step(8);
    check("src_cost_hold", 32'(path_cost), 0);
    check("src_stable", 32'(path_stable), 1);
    rst = 1; clr = 1;
    step(1);
    rst = 0; clr = 0;
    check("rstclr_cost", 32'(path_cost), 32'hFFF);
    check("rstclr_inacc", 32'(path_stable), 1);

    // Inaccessible node, then overflow boundary
    set_all(INF); nb[0] = 0; en = 1;
    step(3);
    check("inacc_cost", 32'(path_cost), 32'hFFF);
    check("inacc_mod", 32'(path_mod), 0);
    ld = 1; ld_weight = 0;
    step(1);
    ld = 0; nb[0] = 12'hFFE;
    step(4);
    check("ovf_cost", 32'(path_cost), 32'hFFF);
    check("ovf_stable", 32'(path_stable), 1);
    nb[0] = 12'hFFD;
    step(4);
    check("eq_cost", 32'(path_cost), 32'hFFF);
    nb[0] = 12'hFFC;
    step(1);
    check("edge_cost", 32'(path_cost), 32'hFFE);

    // Freeze mid-sweep, then resume
    rst = 1; en = 0; set_all(INF);
    step(1);
    rst = 0; ld = 1; ld_weight = 1;
    step(1);
    ld = 0; nb[2] = 20; en = 1;
    step(2);
    check("frz_cost1", 32'(path_cost), 24);
    check("frz_dir1", 32'(path_dir), 2);
    en = 0; nb[4] = 5;
    step(5);
    check("frz_hold", 32'(path_cost), 24);
    check("frz_mod", 32'(path_mod), 0);
    en = 1;
    step(1);
    check("frz_cost2", 32'(path_cost), 9);
    check("frz_dir2", 32'(path_dir), 4);
`ifdef NEU_PAR_TRACE_EN
    check("frz_upd", 32'(upd_cnt), 2);
`endif
    step(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
